vigna_fetch_align: RTL

- Instruction-fetch front end of the vigna core with the C extension enabled. It sits between the core's 32-bit instruction bus (i_valid/i_ready/i_addr/i_rdata) and the decode stage.
- Fetches word-aligned 32-bit words and splits them into 16-bit compressed parcels or 32-bit instructions, including 32-bit instructions that span two words.
- Emits one instruction per handshake, tagged with its PC and a compressed flag.
- Compressed-to-32-bit expansion is done downstream in decode, not here.

---
 rtl/vigna_fetch_pkg.sv | 23 ++
 rtl/vigna_fetch_if.sv | 35 +++
 rtl/vigna_parcel_sel.sv | 62 ++++++
 rtl/vigna_fetch_align.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vigna_fetch_pkg.sv
// vigna_fetch_pkg: shared types and helpers for the vigna fetch/align front end.
//   fetch_state_e  : fetch FSM state encoding
//   OPC_LOW_32     : low opcode bits that mark a 32-bit instruction
//   is_compressed  : true when a 16-bit parcel is a compressed instruction
package vigna_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DISP = 2'd2
  } fetch_state_e;

  localparam logic [1:0] OPC_LOW_32 = 2'b11;

  // Only bits [1:0] decide; the mask keeps the whole parcel as the argument.
  function automatic logic is_compressed(input logic [HLEN-1:0] hw);
    return (hw & 16'h0003) != HLEN'(OPC_LOW_32);
  endfunction

endpackage

// File: rtl/vigna_fetch_if.sv
// vigna_fetch_if: bundles the instruction-bus, redirect and decode handshakes.
//   i_valid/i_ready/i_addr/i_rdata : word fetch bus (fetch unit is master)
//   redirect_valid/redirect_pc     : control-flow redirect into fetch
//   inst_valid/inst_ready/inst_*   : instruction stream to decode
interface vigna_fetch_if;
  import vigna_fetch_pkg::*;

  logic            i_valid;
  logic            i_ready;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_compressed;

  modport master (
    output i_valid, i_addr,
    input  i_ready, i_rdata,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc, inst_compressed,
    input  inst_ready
  );

  modport slave (
    input  i_valid, i_addr,
    output i_ready, i_rdata,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc, inst_compressed,
    output inst_ready
  );
endinterface

// File: rtl/vigna_parcel_sel.sv
// vigna_parcel_sel: picks the next instruction out of a fetched word.
//   word/hbuf/hbuf_v/pc_hi : source word, pending spanning low half, pc[1]
//   emit_c      : an instruction is produced (0 when a spanning instr starts)
//   data_c      : instruction, compressed parcels zero-extended
//   comp_c      : instruction is compressed
//   inc_c       : PC increment (0, 2 or 4)
//   word_done_c : word fully consumed, fetch the next one
//   span_start_c: upper half begins a 32-bit instruction crossing the word
module vigna_parcel_sel
  import vigna_fetch_pkg::*;
#(
  parameter bit C_EXT = 1'b1
) (
  input  logic [XLEN-1:0] word,
  input  logic [HLEN-1:0] hbuf,
  input  logic            hbuf_v,
  input  logic            pc_hi,
  output logic            emit_c,
  output logic [XLEN-1:0] data_c,
  output logic            comp_c,
  output logic [2:0]      inc_c,
  output logic            word_done_c,
  output logic            span_start_c
);

  logic odd_c;
  logic lo_comp_c;
  logic hi_comp_c;

  always_comb begin
    odd_c        = C_EXT && pc_hi;
    lo_comp_c    = C_EXT && is_compressed(word[15:0]);
    hi_comp_c    = C_EXT && is_compressed(word[31:16]);
    emit_c       = 1'b1;
    data_c       = word;
    comp_c       = 1'b0;
    inc_c        = 3'd4;
    word_done_c  = 1'b1;
    span_start_c = 1'b0;
    if (hbuf_v) begin
      // Completes a spanning instruction; dispatch resumes at the upper half.
      data_c      = {word[15:0], hbuf};
      word_done_c = 1'b0;
    end else if (!odd_c) begin
      if (lo_comp_c) begin
        data_c      = {16'h0000, word[15:0]};
        comp_c      = 1'b1;
        inc_c       = 3'd2;
        word_done_c = 1'b0;
      end
    end else if (hi_comp_c) begin
      data_c = {16'h0000, word[31:16]};
      comp_c = 1'b1;
      inc_c  = 3'd2;
    end else begin
      emit_c       = 1'b0;
      inc_c        = 3'd0;
      span_start_c = 1'b1;
    end
  end

endmodule

// File: rtl/vigna_fetch_align.sv
// vigna_fetch_align: fetches 32-bit words and aligns them into 16/32-bit
// instructions for decode.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vigna_fetch_if.master (fetch bus, redirect, decode stream)
module vigna_fetch_align
  import vigna_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          C_EXT    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  vigna_fetch_if.master bus
);

  localparam logic [XLEN-1:0] PC_MASK = C_EXT ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] wbuf_q, wbuf_d;
  logic            wbuf_v_q, wbuf_v_d;
  logic [HLEN-1:0] hbuf_q, hbuf_d;
  logic            hbuf_v_q, hbuf_v_d;
  logic            discard_q, discard_d;
  logic            i_valid_q, i_valid_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_comp_q, inst_comp_d;

  logic [XLEN-1:0] fetch_pc_c;
  logic [XLEN-1:0] src_word_c;
  logic            slot_free_c;
  logic            take_c;
  logic            emit_c;
  logic [XLEN-1:0] data_c;
  logic            comp_c;
  logic [2:0]      inc_c;
  logic            word_done_c;
  logic            span_start_c;

  // A pending spanning instruction needs the word after its odd-half PC.
  assign fetch_pc_c  = pc_q + (hbuf_v_q ? 32'd2 : 32'd0);
  // Dispatch straight from the bus on the accept cycle for zero-bubble latency.
  assign src_word_c  = (state_q == S_WAIT) ? bus.i_rdata : wbuf_q;
  assign slot_free_c = !inst_valid_q || bus.inst_ready;

  vigna_parcel_sel #(.C_EXT(C_EXT)) u_sel (
    .word         (src_word_c),
    .hbuf         (hbuf_q),
    .hbuf_v       (hbuf_v_q),
    .pc_hi        (pc_q[1]),
    .emit_c       (emit_c),
    .data_c       (data_c),
    .comp_c       (comp_c),
    .inc_c        (inc_c),
    .word_done_c  (word_done_c),
    .span_start_c (span_start_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wbuf_d       = wbuf_q;
    wbuf_v_d     = wbuf_v_q;
    hbuf_d       = hbuf_q;
    hbuf_v_d     = hbuf_v_q;
    discard_d    = discard_q;
    i_valid_d    = i_valid_q;
    i_addr_d     = i_addr_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_comp_d  = inst_comp_q;
    take_c       = 1'b0;

    if (inst_valid_q && bus.inst_ready) inst_valid_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        i_valid_d = 1'b1;
        i_addr_d  = {fetch_pc_c[31:2], 2'b00};
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_ready) begin
          i_valid_d = 1'b0;
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            wbuf_d   = bus.i_rdata;
            wbuf_v_d = 1'b1;
            state_d  = S_DISP;
            take_c   = slot_free_c || span_start_c;
          end
        end
      end
      S_DISP: take_c = wbuf_v_q && (slot_free_c || span_start_c);
      default: state_d = S_REQ;
    endcase

    if (take_c) begin
      if (emit_c) begin
        inst_valid_d = 1'b1;
        inst_data_d  = data_c;
        inst_pc_d    = pc_q;
        inst_comp_d  = comp_c;
      end
      pc_d = pc_q + 32'(inc_c);
      if (hbuf_v_q) hbuf_v_d = 1'b0;
      if (span_start_c) begin
        hbuf_d   = src_word_c[31:16];
        hbuf_v_d = 1'b1;
      end
      if (word_done_c) begin
        wbuf_v_d = 1'b0;
        state_d  = S_REQ;
      end
    end

    // Redirect overrides everything; an outstanding bus request is never
    // aborted, its word is dropped on return instead.
    if (bus.redirect_valid) begin
      inst_valid_d = 1'b0;
      pc_d         = bus.redirect_pc & PC_MASK;
      wbuf_v_d     = 1'b0;
      hbuf_v_d     = 1'b0;
      if (state_q == S_WAIT && !bus.i_ready) begin
        state_d   = S_WAIT;
        i_valid_d = 1'b1;
        discard_d = 1'b1;
      end else begin
        state_d   = S_REQ;
        i_valid_d = 1'b0;
        discard_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC & PC_MASK;
      wbuf_q       <= '0;
      wbuf_v_q     <= 1'b0;
      hbuf_q       <= '0;
      hbuf_v_q     <= 1'b0;
      discard_q    <= 1'b0;
      i_valid_q    <= 1'b0;
      i_addr_q     <= RESET_PC & 32'hFFFF_FFFC;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      inst_comp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wbuf_q       <= wbuf_d;
      wbuf_v_q     <= wbuf_v_d;
      hbuf_q       <= hbuf_d;
      hbuf_v_q     <= hbuf_v_d;
      discard_q    <= discard_d;
      i_valid_q    <= i_valid_d;
      i_addr_q     <= i_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_comp_q  <= inst_comp_d;
    end
  end

  assign bus.i_valid         = i_valid_q;
  assign bus.i_addr          = i_addr_q;
  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst_data       = inst_data_q;
  assign bus.inst_pc         = inst_pc_q;
  assign bus.inst_compressed = inst_comp_q;

endmodule
